// File: rtl/scope_capture_buffer.sv
// Triggered sample-capture RAM for the oscilloscope: records ADC samples into a
// circular buffer around a level/slope trigger and freezes the frame for the VGA reader.
module scope_capture_buffer #(
  parameter int DATA_W       = 12,
  parameter int ADDR_W       = 10,
  parameter int DEPTH        = 1000,
  parameter int PRE_TRIG     = 200,
  parameter int AUTO_TIMEOUT = 51200000
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              sample_clk,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [1:0]        mode,
  input  logic              arm,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic              frame_done,
  input  logic              rd_stb,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] q,
  output logic              frame_ready,
  output logic              forced_trig,
  output logic [2:0]        state_o
);

  localparam int POST_LEN = DEPTH - PRE_TRIG - 1;
  localparam int TO_W     = $clog2(AUTO_TIMEOUT) + 1;

  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   BACK_OFF  = (ADDR_W+1)'(DEPTH - PRE_TRIG);
  localparam logic [ADDR_W-1:0] WR_LAST   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'((PRE_TRIG > 0) ? PRE_TRIG - 1 : 0);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'((POST_LEN > 0) ? POST_LEN - 1 : 0);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(AUTO_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRE_FILL  = 3'd1,
    S_ARMED     = 3'd2,
    S_POST_FILL = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t            state;
  logic              sample_clk_d;
  logic [DATA_W-1:0] prev_sample;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] trig_ptr;
  logic [ADDR_W-1:0] pre_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic [TO_W-1:0]   to_cnt;

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  logic              accept;
  logic              writing;
  logic              hit;
  logic              single_mode;
  logic              auto_mode;
  logic              addr_ok;
  logic [ADDR_W:0]   start_sum;
  logic [ADDR_W:0]   start_idx;
  logic [ADDR_W:0]   rd_sum;
  logic [ADDR_W-1:0] rd_idx;

  assign state_o     = state;
  assign single_mode = mode[1];
  assign auto_mode   = (mode == 2'b00);
  assign accept      = sample_clk & ~sample_clk_d;
  assign writing     = accept && (state == S_PRE_FILL || state == S_ARMED || state == S_POST_FILL);
  assign addr_ok     = ({1'b0, read_addr} < DEPTH_X);

  // Frame origin sits PRE_TRIG samples behind the trigger; adding DEPTH-PRE_TRIG keeps it non-negative.
  always_comb begin
    start_sum = {1'b0, trig_ptr} + BACK_OFF;
    start_idx = (start_sum >= DEPTH_X) ? start_sum - DEPTH_X : start_sum;
    rd_sum    = start_idx + {1'b0, read_addr};
    rd_idx    = ADDR_W'((rd_sum >= DEPTH_X) ? rd_sum - DEPTH_X : rd_sum);
    if (trig_slope)
      hit = (prev_sample >= trig_level) && (sample_data < trig_level);
    else
      hit = (prev_sample < trig_level) && (sample_data >= trig_level);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset_n && writing)
      mem[wr_ptr] <= sample_data;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      sample_clk_d <= 1'b0;
      prev_sample  <= '0;
      wr_ptr       <= '0;
      trig_ptr     <= '0;
      pre_cnt      <= '0;
      post_cnt     <= '0;
      to_cnt       <= '0;
      q            <= '0;
      frame_ready  <= 1'b0;
      forced_trig  <= 1'b0;
    end else begin
      sample_clk_d <= sample_clk;

      if (writing) begin
        wr_ptr      <= (wr_ptr == WR_LAST) ? '0 : wr_ptr + 1'b1;
        prev_sample <= sample_data;
      end

      // While frozen q serves the reader; otherwise it mirrors the live input.
      if (state == S_DONE) begin
        if (rd_stb)
          q <= addr_ok ? mem[rd_idx] : '0;
      end else if (accept) begin
        q <= sample_data;
      end

      if (state != S_ARMED)
        to_cnt <= '0;

      case (state)
        S_IDLE: begin
          if (arm || !single_mode) begin
            state   <= S_PRE_FILL;
            pre_cnt <= '0;
          end
        end
        S_PRE_FILL: begin
          if (PRE_TRIG == 0 || (accept && pre_cnt == PRE_LAST))
            state <= S_ARMED;
          else if (accept)
            pre_cnt <= pre_cnt + 1'b1;
        end
        S_ARMED: begin
          // A genuine trigger takes priority over the auto-mode timeout.
          if (accept && hit) begin
            trig_ptr    <= wr_ptr;
            forced_trig <= 1'b0;
            post_cnt    <= '0;
            to_cnt      <= '0;
            state       <= S_POST_FILL;
          end else if (auto_mode && to_cnt == TO_LAST) begin
            trig_ptr    <= wr_ptr;
            forced_trig <= 1'b1;
            post_cnt    <= '0;
            to_cnt      <= '0;
            state       <= S_POST_FILL;
          end else if (to_cnt != TO_LAST) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_POST_FILL: begin
          if (POST_LEN == 0 || (accept && post_cnt == POST_LAST)) begin
            state       <= S_DONE;
            frame_ready <= 1'b1;
          end else if (accept) begin
            post_cnt <= post_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if ((!single_mode && frame_done) || (single_mode && arm)) begin
            state       <= S_PRE_FILL;
            pre_cnt     <= '0;
            frame_ready <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
